// File: rtl/seg7_pkg.sv
// Shared segment encodings and helpers for the 7-segment scan driver.
package seg7_pkg;

    // Active-low patterns, bit6=g ... bit0=a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [0:0] {StIdle, StConv} conv_state_e;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // 10^n, used to size the overflow threshold at elaboration
    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, result and overflow
// flag registered on the final shift edge alongside a one-cycle done pulse.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned BIN_WIDTH  = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [BIN_WIDTH-1:0]      i_bin,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_ovf,
    output logic [4*NUM_DIGITS-1:0]   o_bcd
);

    localparam int unsigned CntW     = $clog2(BIN_WIDTH);
    localparam logic [31:0] OvfLimit = pow10(NUM_DIGITS);

    conv_state_e             r_state, w_state_next;
    logic [BIN_WIDTH-1:0]    r_shift;
    logic [4*NUM_DIGITS-1:0] r_work, w_work_adj, w_work_next, r_bcd;
    logic [CntW-1:0]         r_cnt;
    logic                    r_ovf_cap, r_ovf, r_done;
    logic                    w_accept, w_last;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Next state: start only honoured in idle, leave after the last shift
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = StConv;
                end
            end
            StConv: begin
                if (r_cnt == CntW'(BIN_WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Add-3 on every BCD nibble >= 5, then shift in the next binary MSB.
    // Truncating to NUM_DIGITS is safe: in-range values never overflow it,
    // and out-of-range values are replaced by dashes downstream.
    always_comb begin
        w_work_adj = r_work;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_work[4*i +: 4] >= 4'd5) w_work_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
        w_work_next = {w_work_adj[4*NUM_DIGITS-2:0], r_shift[BIN_WIDTH-1]};
    end

    // Datapath: capture on accept, shift while converting, publish on last
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_shift   <= i_bin;
                r_work    <= '0;
                r_cnt     <= '0;
                r_ovf_cap <= (32'(i_bin) >= OvfLimit);
            end else if (r_state == StConv) begin
                r_shift <= r_shift << 1;
                r_work  <= w_work_next;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_bcd <= w_work_next;
                r_ovf <= r_ovf_cap;
            end
        end
    end

    assign o_busy = (r_state == StConv);
    assign o_done = r_done;
    assign o_ovf  = r_ovf;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-7-segment multiplexed display driver with leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14,
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_WIDTH-1:0]  value,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned PrescW = $clog2(CLK_DIV);
    localparam int unsigned ScanW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    w_ovf;
    logic [PrescW-1:0]       r_presc;
    logic [ScanW-1:0]        r_scan_idx;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    w_wrap;
    logic                    w_zero_above;
    logic [6:0]              w_digit_seg [NUM_DIGITS];

    // The converter's result register doubles as the display register
    bin2bcd_seq #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (load),
        .i_bin   (value),
        .o_busy  (busy),
        .o_done  (done),
        .o_ovf   (w_ovf),
        .o_bcd   (w_bcd)
    );

    assign w_wrap = (r_presc == PrescW'(CLK_DIV - 1));

    // Per-digit pattern: dashes on overflow, else blank zeros above the MSD
    always_comb begin
        w_zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (w_bcd[4*i +: 4] == 4'd0);
            if (w_ovf) begin
                w_digit_seg[i] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (i != 0) && w_zero_above) begin
                w_digit_seg[i] = SEG_BLANK;
            end else begin
                w_digit_seg[i] = nibble_to_seg(w_bcd[4*i +: 4]);
            end
        end
    end

    // Prescaler and scan: on each wrap present the current index, then advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_scan_idx <= '0;
            r_an       <= '1;
            r_seg      <= SEG_BLANK;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_wrap) begin
                r_an       <= ~(NUM_DIGITS'(1) << r_scan_idx);
                r_seg      <= w_digit_seg[r_scan_idx];
                r_scan_idx <= (r_scan_idx == ScanW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: decimal reference model, directed and random loads.
module tb_seg7_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned BW = 14;
    localparam int unsigned CD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [BW-1:0] value = '0;
    logic          busy, done, busy_nb, done_nb;
    logic [6:0]    seg, seg_nb;
    logic [ND-1:0] an, an_nb;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .CLK_DIV    (CD),
        .BLANK_LZ   (1)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .seg   (seg),
        .an    (an)
    );

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .CLK_DIV    (CD),
        .BLANK_LZ   (0)
    ) u_dut_nb (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .busy  (busy_nb),
        .done  (done_nb),
        .seg   (seg_nb),
        .an    (an_nb)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state, in decimal terms
    int            m_cyc, m_wraps, m_left, m_pend, m_disp;
    logic          m_done;
    logic [ND-1:0] m_an;
    logic [6:0]    m_seg, m_seg_nb;

    logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [6:0] exp_digit(input int val, input int d, input bit blank_lz);
        int p;
        int lim;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        lim = 1;
        for (int k = 0; k < int'(ND); k++) lim = lim * 10;
        if (val >= lim) return 7'b0111111;
        if (blank_lz && (d > 0) && (val < p)) return 7'b1111111;
        return enc[(val / p) % 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_init();
        m_cyc    = 0;
        m_wraps  = 0;
        m_left   = 0;
        m_pend   = 0;
        m_disp   = 0;
        m_done   = 1'b0;
        m_an     = '1;
        m_seg    = 7'b1111111;
        m_seg_nb = 7'b1111111;
    endtask

    // Advance one clock: predict this edge, then compare at the falling edge
    task automatic tick();
        bit accept;
        int d;
        accept = load && (m_left == 0);
        if (((m_cyc + 1) % int'(CD)) == 0) begin
            d        = m_wraps % int'(ND);
            m_an     = ~(ND'(1) << d);
            m_seg    = exp_digit(m_disp, d, 1'b1);
            m_seg_nb = exp_digit(m_disp, d, 1'b0);
            m_wraps++;
        end
        m_done = 1'b0;
        if (m_left == 1) begin
            m_disp = m_pend;
            m_done = 1'b1;
        end
        if (m_left > 0) m_left--;
        if (accept) begin
            m_pend = int'(value);
            m_left = int'(BW);
        end
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
        check("busy",   32'(busy),   32'(m_left > 0));
        check("done",   32'(done),   32'(m_done));
        check("an",     32'(an),     32'(m_an));
        check("seg",    32'(seg),    32'(m_seg));
        check("an_nb",  32'(an_nb),  32'(m_an));
        check("seg_nb", 32'(seg_nb), 32'(m_seg_nb));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_an",   32'(an),   32'hF);
        check("rst_seg",  32'(seg),  32'h7F);
        check("rst_seg_nb", 32'(seg_nb), 32'h7F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_init();
    endtask

    task automatic do_load(input int v, input int gap);
        load  = 1'b1;
        value = BW'(v);
        tick();
        load = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        model_init();
        #2;
        do_reset();
        repeat (10) tick();
        do_load(1234, 30);
        do_load(7, 30);
        do_load(10000, 30);
        do_load(42, 4);
        do_load(99, 26);
        do_load(9999, 6);
        do_reset();
        repeat (20) tick();
        do_load(0, 24);
        do_load(5555, 14);
        do_load(321, 20);
        do_load(100, 13);
        do_load(200, 20);
        do_load(16383, 20);
        do_load(9999, 20);
        repeat (40) begin
            do_load(int'($urandom_range(0, (1 << BW) - 1)), int'($urandom_range(0, 25)));
        end
        repeat (20) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
